tpg_mp: RTL

TPG_MP -- requirements
Module: tpg_mp

---
 rtl/tpg_mp.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/tpg_mp.sv
// tpg_mp: multi-pixel-per-clock video test pattern generator.
// Raster counters run in clock units (PORT_NUM pixels per clock), one
// registered decode stage produces sync/DE/pixel data, and configuration is
// held in shadow registers that reload only at frame boundaries.
module tpg_mp #(
    parameter int unsigned PORT_NUM = 2,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                           PIXEL_CLK_I,
    input  logic                           RESETN_I,
    input  logic [15:0]                    HSYNC_I,
    input  logic [15:0]                    HBP_I,
    input  logic [15:0]                    HACTIVE_I,
    input  logic [15:0]                    HFP_I,
    input  logic [15:0]                    VSYNC_I,
    input  logic [15:0]                    VBP_I,
    input  logic [15:0]                    VACTIVE_I,
    input  logic [15:0]                    VFP_I,
    input  logic [2:0]                     PATTERN_I,
    input  logic [3*DATA_W-1:0]            SOLID_RGB_I,
    input  logic                           EN_I,
    input  logic                           UPDATE_I,
    output logic                           UPDATE_ACK_O,
    output logic                           HS_O,
    output logic                           VS_O,
    output logic                           DE_O,
    output logic [PORT_NUM*3*DATA_W-1:0]   RGB_O,
    output logic [15:0]                    ACTIVE_X_O,
    output logic [15:0]                    ACTIVE_Y_O,
    output logic [15:0]                    FRAME_CNT_O,
    output logic                           SOF_O,
    output logic                           CFG_ERR_O
);

    localparam int unsigned SH = (PORT_NUM == 4) ? 2 : ((PORT_NUM == 2) ? 1 : 0);
    localparam int unsigned PW = 3 * DATA_W;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e                       state_q;
    logic [17:0]                  x_q, y_q;
    logic                         pend_q, ack_q, err_q;
    logic [15:0]                  fcnt_q;
    logic [15:0]                  hsync_q, hbp_q, hact_q, hfp_q;
    logic [15:0]                  vsync_q, vbp_q, vact_q, vfp_q;
    logic [2:0]                   pattern_q;
    logic [PW-1:0]                solid_q;
    logic [15:0]                  barw_q;
    logic                         hs_q, vs_q, de_q, sof_q;
    logic [15:0]                  ax_q, ay_q;
    logic [PORT_NUM*PW-1:0]       rgb_q;

    logic [17:0] h_tot, ht_m1, hs_end, dxs, dxe, v_tot, vt_m1, dys, dye;
    logic        line_end, frame_end, reload, load_en, cfg_bad;
    logic        hs_d, vs_d, de_d;
    logic [15:0] ax_d, ay_d, px;
    logic [2:0]  idx;
    logic [PW-1:0] col;
    logic [PORT_NUM*PW-1:0] rgb_d;

    function automatic logic [PW-1:0] bar_rgb(input logic [2:0] i);
        logic [2:0] f;
        case (i)
            3'd0:    f = 3'b111;
            3'd1:    f = 3'b110;
            3'd2:    f = 3'b011;
            3'd3:    f = 3'b010;
            3'd4:    f = 3'b101;
            3'd5:    f = 3'b100;
            3'd6:    f = 3'b001;
            default: f = 3'b000;
        endcase
        return {{DATA_W{f[2]}}, {DATA_W{f[1]}}, {DATA_W{f[0]}}};
    endfunction

    // Raster limits in clock units derived from the shadow configuration.
    always_comb begin
        h_tot     = 18'(hsync_q) + 18'(hbp_q) + 18'(hact_q) + 18'(hfp_q);
        ht_m1     = (h_tot >> SH) - 18'd1;
        hs_end    = 18'(hsync_q) >> SH;
        dxs       = (18'(hsync_q) + 18'(hbp_q)) >> SH;
        dxe       = (18'(hsync_q) + 18'(hbp_q) + 18'(hact_q)) >> SH;
        v_tot     = 18'(vsync_q) + 18'(vbp_q) + 18'(vact_q) + 18'(vfp_q);
        vt_m1     = v_tot - 18'd1;
        dys       = 18'(vsync_q) + 18'(vbp_q);
        dye       = dys + 18'(vact_q);
        line_end  = (x_q == ht_m1);
        frame_end = line_end && (y_q == vt_m1);
        reload    = pend_q | UPDATE_I;
        load_en   = ((state_q == S_IDLE) && EN_I) ||
                    ((state_q == S_RUN) && frame_end && reload);
        cfg_bad   = (HACTIVE_I == 16'd0) || (VACTIVE_I == 16'd0);
    end

    // Timing decode and per-port pattern generation from the current counters.
    always_comb begin
        hs_d  = (x_q < hs_end);
        vs_d  = (y_q < 18'(vsync_q));
        de_d  = (x_q >= dxs) && (x_q < dxe) && (y_q >= dys) && (y_q < dye);
        ax_d  = de_d ? 16'((x_q - dxs) << SH) : '0;
        ay_d  = de_d ? 16'(y_q - dys) : '0;
        px    = '0;
        idx   = '0;
        col   = '0;
        rgb_d = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            px  = ax_d + 16'(p);
            // Bar index as a count of crossed thresholds k*W, so no divider.
            idx = '0;
            for (int unsigned k = 1; k < 8; k++) begin
                if (32'(px) >= k * 32'(barw_q)) idx = idx + 3'd1;
            end
            case (pattern_q)
                3'd0:    col = solid_q;
                3'd1:    col = bar_rgb(idx);
                3'd2:    col = {3{DATA_W'(px)}};
                3'd3:    col = {PW{px[5] ^ ay_d[5]}};
                default: col = '0;
            endcase
            rgb_d[p*PW +: PW] = de_d ? col : '0;
        end
    end

    // Shadow configuration: captured on enable in IDLE or at a serviced frame end.
    always_ff @(posedge PIXEL_CLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            hsync_q <= '0; hbp_q <= '0; hact_q <= '0; hfp_q <= '0;
            vsync_q <= '0; vbp_q <= '0; vact_q <= '0; vfp_q <= '0;
            pattern_q <= '0;
            solid_q   <= '0;
            barw_q    <= '0;
        end else if (load_en) begin
            hsync_q <= HSYNC_I; hbp_q <= HBP_I; hact_q <= HACTIVE_I; hfp_q <= HFP_I;
            vsync_q <= VSYNC_I; vbp_q <= VBP_I; vact_q <= VACTIVE_I; vfp_q <= VFP_I;
            pattern_q <= PATTERN_I;
            solid_q   <= SOLID_RGB_I;
            barw_q    <= (HACTIVE_I[15:3] == 13'd0) ? 16'd1 : {3'b000, HACTIVE_I[15:3]};
        end
    end

    // Control FSM: raster counters, update handshake, frame count, config error.
    always_ff @(posedge PIXEL_CLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    x_q    <= '0;
                    y_q    <= '0;
                    pend_q <= 1'b0;
                    if (EN_I) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end
                end
                default: begin
                    if (UPDATE_I) pend_q <= 1'b1;
                    if (line_end) begin
                        x_q <= '0;
                        y_q <= (y_q == vt_m1) ? '0 : y_q + 18'd1;
                    end else begin
                        x_q <= x_q + 18'd1;
                    end
                    if (frame_end) begin
                        fcnt_q <= fcnt_q + 16'd1;
                        // A request arriving on the frame-end cycle is serviced here too.
                        if (reload) begin
                            ack_q  <= 1'b1;
                            pend_q <= 1'b0;
                            if (cfg_bad) begin
                                err_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end
                        if (!EN_I) state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Output pipeline register: decoded values aligned one clock after counters.
    always_ff @(posedge PIXEL_CLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0; sof_q <= 1'b0;
            ax_q <= '0; ay_q <= '0; rgb_q <= '0;
        end else if (state_q == S_RUN) begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            sof_q <= (x_q == '0) && (y_q == '0);
            ax_q  <= ax_d;
            ay_q  <= ay_d;
            rgb_q <= rgb_d;
        end else begin
            hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0; sof_q <= 1'b0;
            ax_q <= '0; ay_q <= '0; rgb_q <= '0;
        end
    end

    assign UPDATE_ACK_O = ack_q;
    assign HS_O         = hs_q;
    assign VS_O         = vs_q;
    assign DE_O         = de_q;
    assign RGB_O        = rgb_q;
    assign ACTIVE_X_O   = ax_q;
    assign ACTIVE_Y_O   = ay_q;
    assign FRAME_CNT_O  = fcnt_q;
    assign SOF_O        = sof_q;
    assign CFG_ERR_O    = err_q;

endmodule
